// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the NoC output arbiter.
//   - default flit geometry and framing bit positions
//   - arbiter FSM state encoding
//   - helper for locating a requester's flit inside a packed flit bus
package noc_pkg;

  localparam int NOC_FLIT_W  = 67;
  localparam int NOC_BOP_BIT = 66;
  localparam int NOC_EOP_BIT = 65;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Low bit index of requester idx's flit in a bus of width-w flits.
  function automatic int flit_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/noc_out_arbiter_rr_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Ports:
//   req_i  - request vector
//   ptr_i  - index with highest priority this round
//   gnt_o  - one-hot grant of the first request at or above ptr_i (wrapping)
//   idx_o  - binary index of gnt_o
//   any_o  - at least one request present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int  cand;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    // Visit ptr, ptr+1, ... wrapping; the first set bit wins.
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand[IDX_W-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/noc_out_arbiter_rr.sv
// noc_out_arbiter_rr: round-robin arbiter sharing one NoC output link among
// N_REQ input buffers. A grant is held for a whole packet (BOP..EOP).
// Ports:
//   clk           - clock, rising edge
//   rst           - asynchronous active-low reset
//   req_in        - request per input buffer
//   flit_in       - packed flits, requester i at [i*FLIT_W +: FLIT_W]
//   busy_out      - back-pressure; bit low only when that flit is accepted
//   grant_out     - one-hot current grant, zero when idle
//   FLIT_out      - flit to the output link
//   VALID_out     - FLIT_out valid
//   STALL_in      - downstream not ready
//   pkt_count_out - saturating count of forwarded packets
//   err_out       - sticky framing error (first flit of a grant lacked BOP)
module noc_out_arbiter_rr
  import noc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int FLIT_W  = noc_pkg::NOC_FLIT_W,
  parameter int BOP_BIT = noc_pkg::NOC_BOP_BIT,
  parameter int EOP_BIT = noc_pkg::NOC_EOP_BIT,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_in,
  input  logic [N_REQ*FLIT_W-1:0] flit_in,
  output logic [N_REQ-1:0]        busy_out,
  output logic [N_REQ-1:0]        grant_out,
  output logic [FLIT_W-1:0]       FLIT_out,
  output logic                    VALID_out,
  input  logic                    STALL_in,
  output logic [CNT_W-1:0]        pkt_count_out,
  output logic                    err_out
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]  gidx_q;
  logic [IDX_W-1:0]  ptr_q;
  logic              first_q;   // next transfer is the first of this grant
  logic [CNT_W-1:0]  pkt_cnt_q;
  logic              err_q;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic [FLIT_W-1:0] flit_arr [N_REQ];
  logic [FLIT_W-1:0] cur_flit;
  logic              xfer_fire;
  logic              xfer_eop;
  logic [IDX_W-1:0]  ptr_next;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign flit_arr[gi] = flit_in[flit_lo(gi, FLIT_W) +: FLIT_W];
  end

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req_i(req_in),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  assign cur_flit  = flit_arr[gidx_q];
  assign xfer_fire = (state_q == XFER) && req_in[gidx_q] && !STALL_in;
  assign xfer_eop  = xfer_fire && cur_flit[EOP_BIT];
  assign ptr_next  = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = XFER;
      XFER:    if (xfer_eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_out  = '1;
    FLIT_out  = '0;
    VALID_out = 1'b0;
    if (state_q == XFER) begin
      FLIT_out         = cur_flit;
      VALID_out        = req_in[gidx_q];
      busy_out[gidx_q] = STALL_in;
    end
  end

  assign grant_out     = grant_q;
  assign pkt_count_out = pkt_cnt_q;
  assign err_out       = err_q;

  // Grant, pointer, counter and framing-error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      first_q   <= 1'b0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && pick_any) begin
        grant_q <= pick_gnt;
        gidx_q  <= pick_idx;
        first_q <= 1'b1;
      end
      if (xfer_fire) begin
        first_q <= 1'b0;
        // Forwarding continues even on a framing error; only the flag records it.
        if (first_q && !cur_flit[BOP_BIT]) err_q <= 1'b1;
        if (cur_flit[EOP_BIT]) begin
          grant_q <= '0;
          ptr_q   <= ptr_next;
          if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_out_arbiter_rr.sv
module tb_noc_out_arbiter_rr;

  localparam int N   = 4;
  localparam int FW  = 67;
  localparam int BOP = 66;
  localparam int EOP = 65;
  localparam int CW  = 4;   // narrow counter so saturation is reachable quickly

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_in;
  logic [N*FW-1:0]   flit_in;
  logic [N-1:0]      busy_out;
  logic [N-1:0]      grant_out;
  logic [FW-1:0]     FLIT_out;
  logic              VALID_out;
  logic              STALL_in;
  logic [CW-1:0]     pkt_count_out;
  logic              err_out;

  noc_out_arbiter_rr #(
    .N_REQ(N), .FLIT_W(FW), .BOP_BIT(BOP), .EOP_BIT(EOP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .flit_in(flit_in),
    .busy_out(busy_out), .grant_out(grant_out), .FLIT_out(FLIT_out),
    .VALID_out(VALID_out), .STALL_in(STALL_in),
    .pkt_count_out(pkt_count_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: owner of the link (-1 = nobody), rotation start, counters.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;
  bit m_first = 1'b0;

  // Packet sources, one per requester.
  int       src_len [N];
  int       src_pos [N];
  bit       src_badbop [N];
  bit       rand_len = 1'b0;
  logic [N-1:0] req_v = '0;
  bit       stall_v = 1'b0;

  function automatic logic [FW-1:0] src_flit(input int i);
    logic [FW-1:0] f;
    f        = '0;
    f[31:0]  = $urandom;
    f[63:32] = i * 256 + src_pos[i];
    f[BOP]   = (src_pos[i] == 0) && !src_badbop[i];
    f[EOP]   = (src_pos[i] == src_len[i] - 1);
    return f;
  endfunction

  // One clock cycle: drive at negedge, check at negedge+1, advance the model.
  task automatic step();
    logic [FW-1:0] fl [N];
    logic [N-1:0]  e_grant, e_busy;
    logic [FW-1:0] e_flit;
    logic          e_valid;
    int            o;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      fl[i] = src_flit(i);
      flit_in[i*FW +: FW] = fl[i];
    end
    req_in   = req_v;
    STALL_in = stall_v;
    #1;
    e_grant = '0; e_busy = '1; e_flit = '0; e_valid = 1'b0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_valid          = req_v[m_owner];
      e_flit           = fl[m_owner];
      e_busy[m_owner]  = stall_v;
    end
    check_val("grant", grant_out, e_grant);
    check_val("valid", VALID_out, e_valid);
    check_val("flit",  FLIT_out,  e_flit);
    check_val("busy",  busy_out,  e_busy);
    check_val("count", pkt_count_out, m_cnt);
    check_val("err",   err_out,   m_err);

    if (m_owner < 0) begin
      if (req_v != '0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req_v[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_first = 1'b1;
      end
    end else if (req_v[m_owner] && !stall_v) begin
      o = m_owner;
      if (m_first && !fl[o][BOP]) m_err = 1'b1;
      m_first       = 1'b0;
      src_badbop[o] = 1'b0;
      if (fl[o][EOP]) begin
        src_pos[o] = 0;
        if (rand_len) src_len[o] = $urandom_range(1, 4);
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        m_ptr   = (o + 1) % N;
        m_owner = -1;
        $display("PKT requester=%0d count=%0d err=%0d", o, m_cnt, m_err);
      end else begin
        src_pos[o]++;
      end
    end
    @(posedge clk);
  endtask

  task automatic reset_now(input string tag);
    @(negedge clk);
    rst      = 1'b0;
    req_in   = '0;
    req_v    = '0;
    STALL_in = 1'b0;
    stall_v  = 1'b0;
    #1;
    check_val({tag, "_grant"}, grant_out, 4'b0000);
    check_val({tag, "_busy"},  busy_out,  4'b1111);
    check_val({tag, "_valid"}, VALID_out, 1'b0);
    check_val({tag, "_flit"},  FLIT_out,  '0);
    check_val({tag, "_count"}, pkt_count_out, 0);
    check_val({tag, "_err"},   err_out,   1'b0);
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_err = 1'b0; m_first = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_pos[i] = 0;
      src_badbop[i] = 1'b0;
    end
    #2 rst = 1'b1;
  endtask

  int got_order [$];
  int exp_order [5] = '{0, 1, 2, 3, 0};
  logic [N-1:0] prev_grant;

  initial begin
    rst = 1'b0; req_in = '0; flit_in = '0; STALL_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 2; src_pos[i] = 0; src_badbop[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a 4-flit packet from requester 1.
    src_len[1] = 4;
    req_v = 4'b0010;
    repeat (3) step();
    check_val("t1_pre_grant", grant_out, 4'b0010);
    reset_now("t1_rst");

    // All requesting, 2-flit packets: rotation 0,1,2,3,0.
    for (int i = 0; i < N; i++) src_len[i] = 2;
    req_v = 4'b1111;
    prev_grant = '0;
    for (int c = 0; c < 15; c++) begin
      step();
      #1;
      if (grant_out != '0 && prev_grant == '0) begin
        for (int i = 0; i < N; i++) if (grant_out[i]) got_order.push_back(i);
      end
      prev_grant = grant_out;
    end
    check_val("t2_ngrants", got_order.size(), 5);
    for (int k = 0; k < 5 && k < got_order.size(); k++) check_val("t2_order", got_order[k], exp_order[k]);
    check_val("t2_count", pkt_count_out, 5);
    req_v = '0;
    step();

    // Requester 2, 4 flits, stall 3 cycles on the second flit.
    src_len[2] = 4; src_len[0] = 1;
    req_v = 4'b0100; step();
    req_v = 4'b0101; step();
    stall_v = 1'b1; repeat (3) step();
    check_val("t3_hold_grant", grant_out, 4'b0100);
    stall_v = 1'b0; repeat (3) step();
    repeat (2) step();
    req_v = '0; step();

    // Requester 1 drops its request mid-packet while requester 0 waits.
    src_len[1] = 3; src_len[0] = 1;
    req_v = 4'b0010; step();
    req_v = 4'b0011; step();
    req_v = 4'b0001; repeat (2) step();
    check_val("t4_lock_grant", grant_out, 4'b0010);
    req_v = 4'b0011; repeat (2) step();
    req_v = 4'b0001; repeat (2) step();
    req_v = '0; step();

    // Requester 3 single flit, then pointer must be 0.
    src_len[3] = 1;
    req_v = 4'b1000; repeat (2) step();
    req_v = '0; step();
    for (int i = 0; i < N; i++) src_len[i] = 1;
    req_v = 4'b1111; step();
    #1 check_val("t5_ptr_wrap", grant_out, 4'b0001);
    step();
    req_v = '0; step();

    // Framing error on requester 0, then counter saturation.
    src_badbop[0] = 1'b1; src_len[0] = 2;
    req_v = 4'b0001; repeat (3) step();
    req_v = '0; step();
    check_val("t6_err_set", err_out, 1'b1);
    for (int i = 0; i < N; i++) src_len[i] = 1;
    req_v = 4'b1111; repeat (40) step();
    req_v = '0; step();
    check_val("t6_err_sticky", err_out, 1'b1);
    check_val("t6_sat", pkt_count_out, 4'hF);

    // Randomized traffic.
    reset_now("rand_rst");
    rand_len = 1'b1;
    for (int i = 0; i < N; i++) src_len[i] = $urandom_range(1, 4);
    for (int c = 0; c < 1500; c++) begin
      req_v   = 4'($urandom_range(0, 15));
      stall_v = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 200) == 0) src_badbop[$urandom_range(0, N-1)] = 1'b1;
      step();
    end
    reset_now("end_rst");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/noc_out_arbiter_rr.md
Name: noc_out_arbiter_rr

Overview:
- Round-robin output-channel arbiter for the NoC router.
- Shares one output link among N_REQ input buffers; each buffer presents request/flit and receives a busy back-pressure signal.
- Grant is held for a whole packet (BOP to EOP) and drives the link through a VALID/STALL handshake.
- Sits between the input buffers' request/flit/busy interface and the router output port.

Parameters:
N_REQ, 4, number of requesting input buffers (2..8)
FLIT_W, 67, flit width in bits
BOP_BIT, 66, begin-of-packet framing bit index in flit
EOP_BIT, 65, end-of-packet framing bit index in flit
CNT_W, 16, width of forwarded-packet counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_in  in  N_REQ  request per input buffer
flit_in  in  N_REQ*FLIT_W  packed flits; requester i at bits [i*FLIT_W +: FLIT_W]
busy_out  out  N_REQ  back-pressure per requester; 0 only when that requester's flit is accepted this cycle
grant_out  out  N_REQ  one-hot current grant; all-zero when idle
FLIT_out  out  FLIT_W  flit to output link
VALID_out  out  1  FLIT_out valid
STALL_in  in  1  downstream not ready
pkt_count_out  out  CNT_W  packets forwarded, saturating
err_out  out  1  sticky framing error

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-low.
- Reset values:
  - state=IDLE, grant=0, rr pointer=0, pkt_count=0, err=0.
  - Outputs under reset: VALID_out=0, FLIT_out=0, busy_out=all ones.
  - Reset asserted mid-packet aborts immediately; no partial-packet recovery.
- FSM states:
  - IDLE:
    - If req_in != 0, pick the first set bit scanning from pointer upward, wrapping modulo N_REQ.
    - Register a one-hot grant; go to XFER.
    - Otherwise stay in IDLE.
    - Request-to-grant latency is 1 cycle. No flit is accepted in IDLE; busy_out is all ones.
  - XFER (grant index g):
    - FLIT_out = flit_in[g] (combinational mux of the registered grant).
    - VALID_out = req_in[g].
    - busy_out[g] = STALL_in; busy_out for all other requesters = 1.
    - Transfer occurs when req_in[g] && !STALL_in.
    - On a transfer whose flit has EOP_BIT=1: next state IDLE, grant cleared, pointer = (g+1) mod N_REQ, pkt_count += 1 (saturating at all ones).
    - If req_in[g] drops mid-packet: stay in XFER, keep the grant, VALID_out=0 (packet lock).
- Framing check:
  - The first transfer after each grant must have BOP_BIT=1; otherwise set err (sticky until reset) and continue forwarding.
  - A single-flit packet (BOP=1 and EOP=1) releases after that one transfer.
- Outside XFER, FLIT_out=0 and VALID_out=0.
- Boundaries:
  - EOP transfer and a new request in the same cycle: one-cycle bubble is mandatory (IDLE re-arbitrates). Back-to-back packets from the same requester therefore have one idle cycle between them.
  - STALL_in held high indefinitely: grant, FLIT_out and VALID_out hold steady.
  - Only one requester active: it is re-granted after each bubble regardless of pointer.
  - Pointer wraps N_REQ-1 -> 0.
  - Grant never changes inside a packet, even if higher-priority requests arrive.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W, BOP_BIT, EOP_BIT
  - state encoding: IDLE=1'b0, XFER=1'b1
  - helper constants for packed flit slicing
- One sub-module, rr_pick:
  - Combinational round-robin priority encoder.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any.
- FSM, counters and mux live in noc_out_arbiter_rr.

Test Plan:
1. Reset mid-XFER (grant=0010, 2 flits sent of a 4-flit packet) -> same cycle grant=0, busy_out=1111, VALID_out=0, pkt_count=0, err=0; next arbitration starts from requester 0.
2. req_in=1111 continuously, each requester sends 2-flit packets (BOP, then EOP), STALL_in=0 -> grant order 0,1,2,3,0; each packet takes 3 cycles (1 arb + 2 xfer); pkt_count=5 after 15 cycles.
3. Requester 2 sends a 4-flit packet with STALL_in=1 on the 2nd flit for 3 cycles -> FLIT_out holds flit 2 and busy_out[2]=1 for 3 cycles; no other grant appears; release after the EOP transfer.
4. Requester 1 drops req mid-packet for 2 cycles while req_in[0]=1 -> grant stays 0010, VALID_out=0 for 2 cycles, busy_out[0]=1 throughout; packet completes and only then is requester 0 granted.
5. Requester 3 sends a single flit with BOP=1, EOP=1 -> granted 1 cycle after request, one transfer, IDLE next cycle, pointer=0, pkt_count +1.
6. First granted flit has BOP=0 -> err_out=1 after that transfer and stays set across later correct packets until reset; pkt_count preset to 16'hFFFF does not wrap on the next EOP.
